pifo_rank_queue: RTL and testbench
==================================

Name: pifo_rank_queue

Overview:
- Shift-register PIFO that consumes the 32-bit rank words produced by the WRR rank engine and keeps them sorted by rank.
- Heads of line are popped by the egress scheduler through a valid/ready interface.
- On every pop it returns the dequeued {overflow, round} on the last_pifo_* feedback bus, which drives the WRR engine's outdated-class check.
- Sits directly downstream of the WRR engine in the root PIFO path.

Parameters:
- DEPTH, 16, number of rank entries (power of 2, >=2)
- META_WIDTH, 16, opaque descriptor width carried with each rank (packet/buffer id)
- PIFO_OVERFLOW_WIDTH, 1, epoch (overflow) field width
- PIFO_ROUND_WIDTH, 18, round field width
- PIFO_ADDR_WIDTH, 12, low address field width
- RESULT_WIDTH, 32, rank word width; equals 1+PIFO_OVERFLOW_WIDTH+PIFO_ROUND_WIDTH+PIFO_ADDR_WIDTH

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- ins_valid  in  1  insert request (WRR engine resp_valid)
- ins_rank  in  RESULT_WIDTH  rank word {vld, overflow, round, addr}
- ins_meta  in  META_WIDTH  descriptor stored with the rank
- ins_ready  out  1  entry available
- deq_valid  out  1  queue non-empty
- deq_rank  out  RESULT_WIDTH  head rank word
- deq_meta  out  META_WIDTH  head descriptor
- deq_ready  in  1  pop head
- last_pifo_valid  out  1  one-cycle pulse, pop occurred
- last_pifo_overflow  out  PIFO_OVERFLOW_WIDTH  overflow of last popped rank
- last_pifo_round  out  PIFO_ROUND_WIDTH  round of last popped rank
- count  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset: rstn is synchronous and active-low; clk is the clock.
- Reset values: all entries invalid; count=0; deq_valid=0; deq_rank=0; deq_meta=0; ins_ready=1; last_pifo_valid=0; last_pifo_overflow=0; last_pifo_round=0; cur_ovf=0.
- Reset mid-operation: discards all entries and the epoch on the next edge.
- Storage: DEPTH registers {rank, meta}, sorted ascending, entry 0 = head.
- deq_valid/deq_rank/deq_meta are driven directly from entry 0. Zero-latency head view; deq_rank=0 when empty.
- ins_ready = (count < DEPTH). An insert is accepted when ins_valid && ins_ready. ins_valid while full is dropped; state and count are unchanged.
- Pop occurs when deq_valid && deq_ready. deq_ready while empty is ignored and no last_pifo pulse is produced.
- On pop, the following are registered on the same edge: last_pifo_valid=1 for one cycle, last_pifo_overflow/round = popped fields, cur_ovf = popped overflow.
- Sort key = {ovf != cur_ovf_eff, round}, compared unsigned.
  - cur_ovf_eff = popped overflow if a pop occurs this cycle, else cur_ovf.
  - Ranks from the next epoch sort after all current-epoch ranks.
  - The addr field and bit RESULT_WIDTH-1 are ignored in comparison.
- Insert position: the first index i whose key is strictly greater than the new key. Equal keys are therefore FIFO. Entries at i and above shift up by one.
- Simultaneous insert+pop: the array shifts down by one and the new element is placed into the post-pop order within the same cycle; count is unchanged. Accepted even when count==DEPTH (ins_ready still reads 0 then; the bench does not rely on this).
- Insert-only: count+1. Pop-only: count-1. Result is visible one cycle after the edge.
- Epoch wrap: when the popped overflow differs from cur_ovf, all remaining entries are in the new epoch by construction, so no resort is needed.

Decomposition:
- Shared package: RESULT_WIDTH, PIFO_OVERFLOW_WIDTH, PIFO_ROUND_WIDTH, PIFO_ADDR_WIDTH field offsets, a rank-field extract function, and the entry struct {rank, meta}. The package is also used by the WRR engine.
- One natural sub-module, pifo_rank_cmp: combinational key compare (new vs entry, cur_ovf_eff) returning greater-than, instantiated DEPTH times.

Test Plan:
- Reset, then insert rounds 5, 2, 9 (ovf 0) on consecutive cycles -> after 3 cycles count=3, deq_rank round=2. Popping three times yields rounds 2, 5, 9, with last_pifo_round pulsing 2, 5, 9 one cycle after each pop.
- Insert round 4 meta=A, then round 4 meta=B -> pops return A then B (FIFO on equal key).
- cur_ovf=0: insert {ovf1, round 1}, then {ovf0, round 200} -> head is round 200. After popping it, head is {ovf1, round 1}. Popping that drives last_pifo_overflow=1; a subsequent insert {ovf0, round 0} sorts after {ovf1, round x}.
- Fill DEPTH=16 entries -> ins_ready=0, count=16. A further ins_valid is dropped and count stays 16. A pop with deq_ready=1 restores ins_ready=1 on the next cycle.
- Queue holds round 3; same-cycle pop + insert round 1 -> next cycle count=1, head round 1, last_pifo_round=3.
- Pop with deq_ready=1 while empty -> no last_pifo_valid pulse, count stays 0. Assert rstn=0 with 5 entries present -> next cycle count=0, deq_valid=0, last_pifo_overflow=0.

Source files
------------

// File: rtl/pifo_rank_queue_pkg.sv
// Shared rank-word layout for the WRR engine and root PIFO: field widths, offsets, extractors, entry payload.
package pifo_rank_queue_pkg;

    localparam int unsigned PIFO_OVERFLOW_WIDTH = 1;
    localparam int unsigned PIFO_ROUND_WIDTH    = 18;
    localparam int unsigned PIFO_ADDR_WIDTH     = 12;
    localparam int unsigned RESULT_WIDTH        = 1 + PIFO_OVERFLOW_WIDTH + PIFO_ROUND_WIDTH + PIFO_ADDR_WIDTH;
    localparam int unsigned META_WIDTH          = 16;

    localparam int unsigned ADDR_LSB  = 0;
    localparam int unsigned ROUND_LSB = ADDR_LSB + PIFO_ADDR_WIDTH;
    localparam int unsigned OVF_LSB   = ROUND_LSB + PIFO_ROUND_WIDTH;
    localparam int unsigned VLD_BIT   = RESULT_WIDTH - 1;
    localparam int unsigned KEY_WIDTH = 1 + PIFO_ROUND_WIDTH;

    typedef logic [RESULT_WIDTH-1:0] rank_t;

    typedef struct packed {
        rank_t                 rank;
        logic [META_WIDTH-1:0] meta;
    } pifo_entry_t;

    function automatic logic [PIFO_OVERFLOW_WIDTH-1:0] rank_ovf(input rank_t r);
        return r[OVF_LSB +: PIFO_OVERFLOW_WIDTH];
    endfunction

    function automatic logic [PIFO_ROUND_WIDTH-1:0] rank_round(input rank_t r);
        return r[ROUND_LSB +: PIFO_ROUND_WIDTH];
    endfunction

endpackage

// File: rtl/pifo_rank_cmp.sv
// Combinational sort-key compare: high when the stored entry's key is strictly greater than the new key.
module pifo_rank_cmp
    import pifo_rank_queue_pkg::*;
(
    input  logic [RESULT_WIDTH-1:0]        new_rank,
    input  logic [RESULT_WIDTH-1:0]        ent_rank,
    input  logic [PIFO_OVERFLOW_WIDTH-1:0] cur_ovf_eff,
    output logic                           gt_c
);

    logic [KEY_WIDTH-1:0] new_key;
    logic [KEY_WIDTH-1:0] ent_key;

    // Next-epoch ranks get the top key bit so they order after the whole current epoch.
    assign new_key = {rank_ovf(new_rank) != cur_ovf_eff, rank_round(new_rank)};
    assign ent_key = {rank_ovf(ent_rank) != cur_ovf_eff, rank_round(ent_rank)};
    assign gt_c    = ent_key > new_key;

endmodule

// File: rtl/pifo_rank_queue.sv
// Shift-register PIFO of rank words sorted by {epoch, round}; head popped via valid/ready, pop feedback to WRR.
module pifo_rank_queue
    import pifo_rank_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           ins_valid,
    input  logic [RESULT_WIDTH-1:0]        ins_rank,
    input  logic [META_WIDTH-1:0]          ins_meta,
    output logic                           ins_ready,
    output logic                           deq_valid,
    output logic [RESULT_WIDTH-1:0]        deq_rank,
    output logic [META_WIDTH-1:0]          deq_meta,
    input  logic                           deq_ready,
    output logic                           last_pifo_valid,
    output logic [PIFO_OVERFLOW_WIDTH-1:0] last_pifo_overflow,
    output logic [PIFO_ROUND_WIDTH-1:0]    last_pifo_round,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    pifo_entry_t                    ent_q [DEPTH];
    logic [DEPTH-1:0]               vld_q;
    logic [CW-1:0]                  count_q;
    logic [PIFO_OVERFLOW_WIDTH-1:0] cur_ovf_q;

    pifo_entry_t                    src_ent [DEPTH];
    pifo_entry_t                    sh_ent  [DEPTH];
    pifo_entry_t                    nxt_ent [DEPTH];
    pifo_entry_t                    new_ent_c;
    logic [DEPTH-1:0]               src_vld;
    logic [DEPTH-1:0]               sh_vld;
    logic [DEPTH-1:0]               nxt_vld;
    logic [DEPTH-1:0]               gt_c;
    logic [DEPTH-1:0]               place_c;
    logic [CW-1:0]                  pos_c;
    logic                           pop_c;
    logic                           do_ins_c;
    logic [PIFO_OVERFLOW_WIDTH-1:0] cur_ovf_eff_c;

    assign deq_valid = vld_q[0];
    assign deq_rank  = ent_q[0].rank;
    assign deq_meta  = ent_q[0].meta;
    assign ins_ready = count_q < CW'(DEPTH);
    assign count     = count_q;

    assign pop_c         = vld_q[0] && deq_ready;
    assign do_ins_c      = ins_valid && (ins_ready || pop_c);
    assign cur_ovf_eff_c = pop_c ? rank_ovf(ent_q[0].rank) : cur_ovf_q;
    assign new_ent_c     = '{rank: ins_rank, meta: ins_meta};

    // Post-pop view of the array, its one-slot-up shift, and per-slot compares against it.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if (g < DEPTH - 1) begin : g_src
            assign src_ent[g] = pop_c ? ent_q[g+1] : ent_q[g];
            assign src_vld[g] = pop_c ? vld_q[g+1] : vld_q[g];
        end else begin : g_src_top
            assign src_ent[g] = pop_c ? '0 : ent_q[g];
            assign src_vld[g] = pop_c ? 1'b0 : vld_q[g];
        end
        if (g == 0) begin : g_sh0
            assign sh_ent[g] = src_ent[g];
            assign sh_vld[g] = src_vld[g];
        end else begin : g_sh
            assign sh_ent[g] = src_ent[g-1];
            assign sh_vld[g] = src_vld[g-1];
        end

        pifo_rank_cmp u_cmp (
            .new_rank    (ins_rank),
            .ent_rank    (src_ent[g].rank),
            .cur_ovf_eff (cur_ovf_eff_c),
            .gt_c        (gt_c[g])
        );

        assign place_c[g] = !src_vld[g] || gt_c[g];
    end

    // First slot whose key is strictly greater (or empty); equal keys stay FIFO.
    always_comb begin
        pos_c = CW'(DEPTH);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (place_c[i]) pos_c = CW'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nxt_ent[i] = src_ent[i];
            nxt_vld[i] = src_vld[i];
            if (do_ins_c) begin
                if (pos_c == CW'(i)) begin
                    nxt_ent[i] = new_ent_c;
                    nxt_vld[i] = 1'b1;
                end else if (pos_c < CW'(i)) begin
                    nxt_ent[i] = sh_ent[i];
                    nxt_vld[i] = sh_vld[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            vld_q              <= '0;
            count_q            <= '0;
            cur_ovf_q          <= '0;
            last_pifo_valid    <= 1'b0;
            last_pifo_overflow <= '0;
            last_pifo_round    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= nxt_ent[i];
            vld_q           <= nxt_vld;
            count_q         <= count_q + CW'(do_ins_c) - CW'(pop_c);
            last_pifo_valid <= pop_c;
            if (pop_c) begin
                last_pifo_overflow <= rank_ovf(ent_q[0].rank);
                last_pifo_round    <= rank_round(ent_q[0].rank);
                cur_ovf_q          <= rank_ovf(ent_q[0].rank);
            end
        end
    end

endmodule

// File: tb/tb_pifo_rank_queue.sv
// Directed bench for pifo_rank_queue with an expected-pop scoreboard.
module tb_pifo_rank_queue;
    import pifo_rank_queue_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic                           clk = 1'b0;
    logic                           rstn;
    logic                           ins_valid;
    logic [RESULT_WIDTH-1:0]        ins_rank;
    logic [META_WIDTH-1:0]          ins_meta;
    logic                           ins_ready;
    logic                           deq_valid;
    logic [RESULT_WIDTH-1:0]        deq_rank;
    logic [META_WIDTH-1:0]          deq_meta;
    logic                           deq_ready;
    logic                           last_pifo_valid;
    logic [PIFO_OVERFLOW_WIDTH-1:0] last_pifo_overflow;
    logic [PIFO_ROUND_WIDTH-1:0]    last_pifo_round;
    logic [$clog2(DEPTH):0]         count;

    typedef struct {
        logic [PIFO_OVERFLOW_WIDTH-1:0] ovf;
        logic [PIFO_ROUND_WIDTH-1:0]    round;
        logic [META_WIDTH-1:0]          meta;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    pifo_rank_queue #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .ins_valid          (ins_valid),
        .ins_rank           (ins_rank),
        .ins_meta           (ins_meta),
        .ins_ready          (ins_ready),
        .deq_valid          (deq_valid),
        .deq_rank           (deq_rank),
        .deq_meta           (deq_meta),
        .deq_ready          (deq_ready),
        .last_pifo_valid    (last_pifo_valid),
        .last_pifo_overflow (last_pifo_overflow),
        .last_pifo_round    (last_pifo_round),
        .count              (count)
    );

    always #5 clk = ~clk;

    function automatic rank_t mk(input logic [PIFO_OVERFLOW_WIDTH-1:0] ovf,
                                 input logic [PIFO_ROUND_WIDTH-1:0] round,
                                 input logic [PIFO_ADDR_WIDTH-1:0] addr);
        return {1'b1, ovf, round, addr};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input logic [PIFO_OVERFLOW_WIDTH-1:0] ovf,
                          input logic [PIFO_ROUND_WIDTH-1:0] round,
                          input logic [META_WIDTH-1:0] meta);
        ins_valid = 1'b1;
        ins_rank  = mk(ovf, round, meta[PIFO_ADDR_WIDTH-1:0]);
        ins_meta  = meta;
        tick();
        ins_valid = 1'b0;
    endtask

    task automatic expect_pop(input logic [PIFO_OVERFLOW_WIDTH-1:0] ovf,
                              input logic [PIFO_ROUND_WIDTH-1:0] round,
                              input logic [META_WIDTH-1:0] meta);
        exp_t e;
        e.ovf   = ovf;
        e.round = round;
        e.meta  = meta;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty observed=pop expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_deq_valid"}, 64'(deq_valid), 64'(1'b1));
        chk({tag, "_head_ovf"},  64'(rank_ovf(deq_rank)), 64'(e.ovf));
        chk({tag, "_head_round"}, 64'(rank_round(deq_rank)), 64'(e.round));
        chk({tag, "_head_meta"}, 64'(deq_meta), 64'(e.meta));
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        chk({tag, "_last_valid"}, 64'(last_pifo_valid), 64'(1'b1));
        chk({tag, "_last_ovf"},   64'(last_pifo_overflow), 64'(e.ovf));
        chk({tag, "_last_round"}, 64'(last_pifo_round), 64'(e.round));
    endtask

    initial begin
        rstn      = 1'b0;
        ins_valid = 1'b0;
        ins_rank  = '0;
        ins_meta  = '0;
        deq_ready = 1'b0;
        tick();
        tick();
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_deq_valid", 64'(deq_valid), 64'(0));
        chk("rst_deq_rank", 64'(deq_rank), 64'(0));
        chk("rst_deq_meta", 64'(deq_meta), 64'(0));
        chk("rst_ins_ready", 64'(ins_ready), 64'(1));
        chk("rst_last_valid", 64'(last_pifo_valid), 64'(0));
        chk("rst_last_round", 64'(last_pifo_round), 64'(0));
        rstn = 1'b1;
        tick();

        // Basic sort
        insert(0, 5, 16'h0001);
        insert(0, 2, 16'h0002);
        insert(0, 9, 16'h0003);
        chk("sort_count", 64'(count), 64'(3));
        chk("sort_head", 64'(rank_round(deq_rank)), 64'(2));
        expect_pop(0, 2, 16'h0002);
        expect_pop(0, 5, 16'h0001);
        expect_pop(0, 9, 16'h0003);
        pop_chk("sort_p0");
        pop_chk("sort_p1");
        pop_chk("sort_p2");
        tick();
        chk("sort_pulse_end", 64'(last_pifo_valid), 64'(0));
        chk("sort_empty", 64'(count), 64'(0));

        // Equal keys stay FIFO
        insert(0, 4, 16'h000A);
        insert(0, 4, 16'h000B);
        expect_pop(0, 4, 16'h000A);
        expect_pop(0, 4, 16'h000B);
        pop_chk("fifo_p0");
        pop_chk("fifo_p1");

        // Epoch ordering and wrap
        insert(1, 1, 16'h0011);
        insert(0, 200, 16'h0022);
        chk("epoch_head", 64'(rank_round(deq_rank)), 64'(200));
        expect_pop(0, 200, 16'h0022);
        expect_pop(1, 1, 16'h0011);
        pop_chk("epoch_p0");
        pop_chk("epoch_p1");
        insert(0, 0, 16'h0033);
        insert(1, 50, 16'h0044);
        chk("epoch_wrap_head_ovf", 64'(rank_ovf(deq_rank)), 64'(1));
        expect_pop(1, 50, 16'h0044);
        expect_pop(0, 0, 16'h0033);
        pop_chk("epoch_p2");
        pop_chk("epoch_p3");

        // Full queue and drop
        for (int i = 0; i < DEPTH; i++) insert(0, PIFO_ROUND_WIDTH'(DEPTH - 1 - i), META_WIDTH'(i));
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_ins_ready", 64'(ins_ready), 64'(0));
        insert(0, 0, 16'h00FF);
        chk("drop_count", 64'(count), 64'(DEPTH));
        for (int r = 0; r < DEPTH; r++) expect_pop(0, PIFO_ROUND_WIDTH'(r), META_WIDTH'(DEPTH - 1 - r));
        pop_chk("full_p0");
        chk("full_ready_back", 64'(ins_ready), 64'(1));
        chk("full_count_15", 64'(count), 64'(DEPTH - 1));
        for (int r = 1; r < DEPTH; r++) pop_chk("drain");
        chk("drain_empty", 64'(deq_valid), 64'(0));

        // Simultaneous pop and insert
        insert(0, 3, 16'h0055);
        ins_valid = 1'b1;
        ins_rank  = mk(0, 1, 12'h066);
        ins_meta  = 16'h0066;
        deq_ready = 1'b1;
        tick();
        ins_valid = 1'b0;
        deq_ready = 1'b0;
        chk("both_count", 64'(count), 64'(1));
        chk("both_head", 64'(rank_round(deq_rank)), 64'(1));
        chk("both_meta", 64'(deq_meta), 64'(16'h0066));
        chk("both_last_valid", 64'(last_pifo_valid), 64'(1));
        chk("both_last_round", 64'(last_pifo_round), 64'(3));
        expect_pop(0, 1, 16'h0066);
        pop_chk("both_p0");

        // Pop while empty
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        chk("empty_pop_pulse", 64'(last_pifo_valid), 64'(0));
        chk("empty_pop_count", 64'(count), 64'(0));

        // Mid-operation reset discards entries and epoch
        insert(1, 7, 16'h0070);
        expect_pop(1, 7, 16'h0070);
        pop_chk("mid_p0");
        for (int i = 0; i < 5; i++) insert(1, PIFO_ROUND_WIDTH'(i + 10), META_WIDTH'(i));
        chk("mid_count", 64'(count), 64'(5));
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mid_rst_count", 64'(count), 64'(0));
        chk("mid_rst_deq_valid", 64'(deq_valid), 64'(0));
        chk("mid_rst_last_ovf", 64'(last_pifo_overflow), 64'(0));
        insert(1, 5, 16'h0081);
        insert(0, 10, 16'h0082);
        chk("mid_rst_epoch_head", 64'(rank_round(deq_rank)), 64'(10));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
